jtshouse_colmix: RTL and testbench
==================================

// Module: jtshouse_colmix
// PURPOSE
// Colour mixer downstream of the C123 tilemap line buffer: merges tilemap pixel/priority with
// the object pixel/priority, looks up the winner in the C116-style palette BRAM (separate R,G,B)
// and drives 24-bit RGB to the video output. Also hosts the C116 raster-interrupt registers.
// PARAMETERS
// HIRQ     9'h040   hdump value at which a matching raster line raises irq
// OBJ_TRN  8'hFF    object colour LSB byte meaning transparent
// PORTS
// clk         in   1   system clock
// rst         in   1   asynchronous, active-high reset
// pxl_cen     in   1   pixel clock enable
// LHBL/LVBL   in   1   active-low blanks, aligned with scr_pxl/obj_pxl
// hdump       in   9   horizontal dump counter
// vdump       in   9   vertical dump counter
// scr_pxl     in   11  tilemap colour index {pal[2:0],colour[7:0]}
// scr_prio    in   3   tilemap priority
// obj_pxl     in   11  object colour index
// obj_prio    in   3   object priority
// pal_addr    out  11  palette BRAM address (1-cycle read latency)
// pal_r/g/b   in   8   palette BRAM data
// cs,rnw      in   1   CPU register select / read-not-write
// addr        in   4   CPU register address
// din         in   8   CPU write data
// dout        out  8   CPU read data (combinational from registers)
// irq         out  1   raster interrupt, level, held until ack
// gfx_en      in   4   bit0=tilemap on, bit3=objects on
// red/green/blue out 8 RGB output
// LHBL_dly/LVBL_dly out 1 blanks delayed to match RGB
// BEHAVIOUR
// Reset: all outputs 0, registers 0, irq 0, pal_addr 0, blanks-delayed 0.
// Registers: 8=raster line[8] (bit0), 9=raster line[7:0], A=irq enable (bit0),
//  B=write-any acks irq (reads 0), C=backdrop[10:8], D=backdrop[7:0]; others read 0, writes ignored.
// Mixing (stage 1, on pxl_cen): obj_opaque = gfx_en[3] && obj_pxl[7:0]!=OBJ_TRN.
//  base = gfx_en[0] ? scr_pxl : backdrop. Object wins if obj_opaque && obj_prio >= scr_prio
//  (gfx_en[0]=0 treats scr_prio as 0). Winner registered into pal_addr.
// Stage 2: palette data valid one clk after pal_addr; captured on next pxl_cen (requires
//  pxl_cen period >= 2 clk). RGB forced to 0 when delayed LHBL or LVBL is low.
// Latency: 2 pxl_cen ticks input->RGB; LHBL/LVBL delayed by same 2 ticks (2-stage shift).
// Without pxl_cen, all pixel state holds.
// irq: set on the clk where pxl_cen && hdump==HIRQ && vdump==raster_line && enable=1.
//  Cleared by CPU write to reg B. Set and ack in the same clk: set wins.
//  Clearing enable does not clear a pending irq.
// CPU writes take effect the clk after cs&~rnw; a raster_line write on the matching clk uses the
//  old value. Raster line beyond vdump range never fires.
// Reset mid-line: pipeline and blanks flush to 0; first valid RGB 2 pxl_cen after release.
// TESTING
// scr=11'h123 prio3, obj=11'h045 prio5 -> pal_addr=045, RGB=pal[045] 2 pxl_cen later
// obj prio2 < scr prio3, or obj_pxl[7:0]=FF -> pal_addr=123; equal prio 3 -> obj wins
// gfx_en=4'b0000, backdrop=7FF -> pal_addr=7FF every pixel, RGB=pal[7FF]
// raster=9'h0F0, enable=1 -> irq rises at vdump=F0,hdump=HIRQ; ack at same clk -> irq stays 1
// LHBL low for 1 pixel -> RGB=0 exactly 2 pxl_cen later, LHBL_dly matches
// assert rst mid-frame with irq pending -> irq=0, RGB=0, registers 0 immediately

Source files
------------

// File: rtl/jtshouse_colmix.sv
// Colour mixer: tilemap/object priority merge, palette BRAM lookup, RGB output
// with matched blank delays, plus the C116 raster-interrupt register block.
`timescale 1ns/1ps
module jtshouse_colmix #(
  parameter logic [8:0] HIRQ    = 9'h040,
  parameter logic [7:0] OBJ_TRN = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pxl_cen,
  input  logic        LHBL,
  input  logic        LVBL,
  input  logic [8:0]  hdump,
  input  logic [8:0]  vdump,
  input  logic [10:0] scr_pxl,
  input  logic [2:0]  scr_prio,
  input  logic [10:0] obj_pxl,
  input  logic [2:0]  obj_prio,
  output logic [10:0] pal_addr,
  input  logic [7:0]  pal_r,
  input  logic [7:0]  pal_g,
  input  logic [7:0]  pal_b,
  input  logic        cs,
  input  logic        rnw,
  input  logic [3:0]  addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        irq,
  input  logic [3:0]  gfx_en,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        LHBL_dly,
  output logic        LVBL_dly
);

  localparam int unsigned CW = 11;
  localparam int unsigned PW = 3;
  localparam int unsigned VW = 9;

  logic [VW-1:0] raster_line;
  logic          irq_en;
  logic [CW-1:0] backdrop;
  logic [1:0]    blank_s1;
  logic          cpu_we;
  logic          irq_set;
  logic          irq_ack;
  logic          obj_opaque;
  logic [PW-1:0] scr_prio_eff;
  logic          obj_win;
  logic [CW-1:0] mix_addr;
  logic          unused_gfx;

  assign unused_gfx = ^gfx_en[2:1];
  assign cpu_we     = cs & ~rnw;
  assign irq_ack    = cpu_we && addr == 4'hB;
  assign irq_set    = pxl_cen && hdump == HIRQ && vdump == raster_line && irq_en;

  // CPU register writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raster_line <= '0;
      irq_en      <= 1'b0;
      backdrop    <= '0;
    end else if (cpu_we) begin
      case (addr)
        4'h8: raster_line[8]   <= din[0];
        4'h9: raster_line[7:0] <= din;
        4'hA: irq_en           <= din[0];
        4'hC: backdrop[10:8]   <= din[2:0];
        4'hD: backdrop[7:0]    <= din;
        default: ;
      endcase
    end
  end

  // Raster interrupt: a set on the same clk as an ack takes priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          irq <= 1'b0;
    else if (irq_set) irq <= 1'b1;
    else if (irq_ack) irq <= 1'b0;
  end

  always_comb begin
    dout = 8'h00;
    case (addr)
      4'h8: dout = {7'd0, raster_line[8]};
      4'h9: dout = raster_line[7:0];
      4'hA: dout = {7'd0, irq_en};
      4'hC: dout = {5'd0, backdrop[10:8]};
      4'hD: dout = backdrop[7:0];
      default: dout = 8'h00;
    endcase
  end

  // Priority merge; a disabled tilemap behaves as priority-0 backdrop
  always_comb begin
    obj_opaque   = gfx_en[3] && obj_pxl[7:0] != OBJ_TRN;
    scr_prio_eff = gfx_en[0] ? scr_prio : PW'(0);
    obj_win      = obj_opaque && obj_prio >= scr_prio_eff;
    mix_addr     = obj_win ? obj_pxl : (gfx_en[0] ? scr_pxl : backdrop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pal_addr <= '0;
      blank_s1 <= 2'b00;
    end else if (pxl_cen) begin
      pal_addr <= mix_addr;
      blank_s1 <= {LHBL, LVBL};
    end
  end

  // Palette data has settled by the next pixel enable; blank it with the delayed blanks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red      <= 8'h00;
      green    <= 8'h00;
      blue     <= 8'h00;
      LHBL_dly <= 1'b0;
      LVBL_dly <= 1'b0;
    end else if (pxl_cen) begin
      red      <= (&blank_s1) ? pal_r : 8'h00;
      green    <= (&blank_s1) ? pal_g : 8'h00;
      blue     <= (&blank_s1) ? pal_b : 8'h00;
      LHBL_dly <= blank_s1[1];
      LVBL_dly <= blank_s1[0];
    end
  end

endmodule

// File: tb/tb_jtshouse_colmix.sv
// Scoreboard bench for jtshouse_colmix: directed pixels with hand-computed palette
// addresses, raster-interrupt register sequences and an asynchronous mid-frame reset.
`timescale 1ns/1ps
module tb_jtshouse_colmix;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pxl_cen = 1'b0;
  logic        LHBL = 1'b1, LVBL = 1'b1;
  logic [8:0]  hdump = '0, vdump = '0;
  logic [10:0] scr_pxl = '0, obj_pxl = '0;
  logic [2:0]  scr_prio = '0, obj_prio = '0;
  logic [10:0] pal_addr;
  logic [7:0]  pal_r = '0, pal_g = '0, pal_b = '0;
  logic        cs = 1'b0, rnw = 1'b1;
  logic [3:0]  addr = '0;
  logic [7:0]  din = '0, dout;
  logic        irq;
  logic [3:0]  gfx_en = 4'b1001;
  logic [7:0]  red, green, blue;
  logic        LHBL_dly, LVBL_dly;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [10:0] addr;
    logic        hb;
    logic        vb;
  } exp_t;

  exp_t q[$];
  exp_t prev;
  bit   have_prev = 0;

  jtshouse_colmix dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .hdump(hdump), .vdump(vdump), .scr_pxl(scr_pxl), .scr_prio(scr_prio),
    .obj_pxl(obj_pxl), .obj_prio(obj_prio), .pal_addr(pal_addr),
    .pal_r(pal_r), .pal_g(pal_g), .pal_b(pal_b), .cs(cs), .rnw(rnw),
    .addr(addr), .din(din), .dout(dout), .irq(irq), .gfx_en(gfx_en),
    .red(red), .green(green), .blue(blue), .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pr(input logic [10:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] pg(input logic [10:0] a);
    return {a[10:8], a[4:0]} ^ 8'h33;
  endfunction
  function automatic logic [7:0] pb(input logic [10:0] a);
    return ~a[7:0] + {5'd0, a[10:8]};
  endfunction

  // Palette BRAM with one clk read latency
  always @(posedge clk) begin
    pal_r <= pr(pal_addr);
    pal_g <= pg(pal_addr);
    pal_b <= pb(pal_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: on each pixel enable, check the previous pixel's RGB and the new pal_addr
  always @(posedge clk or posedge rst) begin
    if (rst) have_prev = 0;
    else if (pxl_cen) begin
      #1;
      if (have_prev) begin
        chk("red",      {24'd0, red},   (prev.hb && prev.vb) ? {24'd0, pr(prev.addr)} : 32'd0);
        chk("green",    {24'd0, green}, (prev.hb && prev.vb) ? {24'd0, pg(prev.addr)} : 32'd0);
        chk("blue",     {24'd0, blue},  (prev.hb && prev.vb) ? {24'd0, pb(prev.addr)} : 32'd0);
        chk("lhbl_dly", {31'd0, LHBL_dly}, {31'd0, prev.hb});
        chk("lvbl_dly", {31'd0, LVBL_dly}, {31'd0, prev.vb});
      end
      if (q.size() > 0) begin
        prev = q.pop_front();
        have_prev = 1;
        chk("pal_addr", {21'd0, pal_addr}, {21'd0, prev.addr});
      end else begin
        have_prev = 0;
      end
    end
  end

  task automatic pixel(input logic [10:0] s, input logic [2:0] sp,
                       input logic [10:0] o, input logic [2:0] op,
                       input logic hb, input logic vb,
                       input logic [8:0] h, input logic [8:0] v,
                       input logic [10:0] exp_addr,
                       input logic we, input logic [3:0] wa, input logic [7:0] wd);
    @(negedge clk);
    scr_pxl = s; scr_prio = sp; obj_pxl = o; obj_prio = op;
    LHBL = hb; LVBL = vb; hdump = h; vdump = v;
    cs = we; rnw = ~we; addr = wa; din = wd;
    q.push_back(exp_t'{exp_addr, hb, vb});
    pxl_cen = 1'b1;
    @(negedge clk);
    pxl_cen = 1'b0; cs = 1'b0; rnw = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic px(input logic [10:0] s, input logic [2:0] sp,
                    input logic [10:0] o, input logic [2:0] op, input logic [10:0] e);
    pixel(s, sp, o, op, 1'b1, 1'b1, 9'd0, 9'd0, e, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic irq_px(input logic [8:0] h, input logic [8:0] v,
                        input logic we, input logic [3:0] wa, input logic [7:0] wd);
    pixel(11'h123, 3'd3, 11'h045, 3'd5, 1'b1, 1'b1, h, v, 11'h045, we, wa, wd);
  endtask

  task automatic idle_tick;
    @(negedge clk);
    pxl_cen = 1'b1;
    @(negedge clk);
    pxl_cen = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rnw = 1'b0; addr = a; din = d;
    @(negedge clk);
    cs = 1'b0; rnw = 1'b1;
  endtask

  task automatic cpu_rd(input string name, input logic [3:0] a, input logic [7:0] e);
    @(negedge clk);
    addr = a;
    #1 chk(name, {24'd0, dout}, {24'd0, e});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pal_addr", {21'd0, pal_addr}, 32'd0);
    chk("rst_rgb", {8'd0, red, green, blue}, 32'd0);
    chk("rst_blanks", {30'd0, LHBL_dly, LVBL_dly}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    cpu_wr(4'hC, 8'hFF);
    cpu_wr(4'hD, 8'hFF);
    cpu_rd("rd_bd_hi", 4'hC, 8'h07);
    cpu_rd("rd_bd_lo", 4'hD, 8'hFF);
    cpu_wr(4'h8, 8'h00);
    cpu_wr(4'h9, 8'hF0);
    cpu_wr(4'hA, 8'h01);
    cpu_rd("rd_raster", 4'h9, 8'hF0);
    cpu_rd("rd_en", 4'hA, 8'h01);
    cpu_rd("rd_unused", 4'h3, 8'h00);

    // Priority merge vectors
    gfx_en = 4'b1001;
    px(11'h123, 3'd3, 11'h045, 3'd5, 11'h045);
    px(11'h123, 3'd3, 11'h045, 3'd2, 11'h123);
    px(11'h123, 3'd3, 11'h0FF, 3'd5, 11'h123);
    px(11'h123, 3'd3, 11'h045, 3'd3, 11'h045);
    px(11'h6AB, 3'd7, 11'h3C1, 3'd6, 11'h6AB);
    pixel(11'h123, 3'd3, 11'h045, 3'd5, 1'b0, 1'b1, 9'd0, 9'd0, 11'h045, 1'b0, 4'h0, 8'h00);
    px(11'h123, 3'd3, 11'h045, 3'd5, 11'h045);
    pixel(11'h321, 3'd1, 11'h045, 3'd0, 1'b1, 1'b0, 9'd0, 9'd0, 11'h321, 1'b0, 4'h0, 8'h00);
    gfx_en = 4'b0000;
    px(11'h123, 3'd3, 11'h045, 3'd7, 11'h7FF);
    px(11'h0AA, 3'd0, 11'h011, 3'd7, 11'h7FF);
    gfx_en = 4'b1000;
    px(11'h123, 3'd7, 11'h045, 3'd0, 11'h045);
    gfx_en = 4'b0001;
    px(11'h123, 3'd0, 11'h045, 3'd7, 11'h123);
    gfx_en = 4'b1001;
    idle_tick;

    // Raster interrupt
    irq_px(9'h03F, 9'h0F0, 1'b0, 4'h0, 8'h00);
    chk("irq_wrong_h", {31'd0, irq}, 32'd0);
    irq_px(9'h040, 9'h0EF, 1'b0, 4'h0, 8'h00);
    chk("irq_wrong_v", {31'd0, irq}, 32'd0);
    irq_px(9'h040, 9'h0F0, 1'b0, 4'h0, 8'h00);
    chk("irq_rise", {31'd0, irq}, 32'd1);
    cpu_wr(4'hB, 8'h5A);
    chk("irq_ack", {31'd0, irq}, 32'd0);
    cpu_rd("rd_ack_reg", 4'hB, 8'h00);
    irq_px(9'h040, 9'h0F0, 1'b1, 4'hB, 8'h00);
    chk("irq_set_wins", {31'd0, irq}, 32'd1);
    cpu_wr(4'hA, 8'h00);
    chk("irq_en_clear_keeps", {31'd0, irq}, 32'd1);
    cpu_wr(4'hB, 8'h00);
    chk("irq_ack2", {31'd0, irq}, 32'd0);
    irq_px(9'h040, 9'h0F0, 1'b0, 4'h0, 8'h00);
    chk("irq_disabled", {31'd0, irq}, 32'd0);
    cpu_wr(4'hA, 8'h01);
    irq_px(9'h040, 9'h0F1, 1'b1, 4'h9, 8'hF1);
    chk("irq_old_raster", {31'd0, irq}, 32'd0);
    cpu_rd("rd_raster_new", 4'h9, 8'hF1);
    irq_px(9'h040, 9'h0F1, 1'b0, 4'h0, 8'h00);
    chk("irq_new_raster", {31'd0, irq}, 32'd1);

    // Asynchronous reset mid-frame with irq pending
    @(negedge clk);
    #2 rst = 1'b1;
    q.delete();
    #1;
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    chk("mid_rst_rgb", {8'd0, red, green, blue}, 32'd0);
    chk("mid_rst_pal_addr", {21'd0, pal_addr}, 32'd0);
    chk("mid_rst_blanks", {30'd0, LHBL_dly, LVBL_dly}, 32'd0);
    addr = 4'h9;
    #1 chk("mid_rst_raster", {24'd0, dout}, 32'd0);
    addr = 4'hC;
    #1 chk("mid_rst_backdrop", {24'd0, dout}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    px(11'h123, 3'd3, 11'h045, 3'd5, 11'h045);
    gfx_en = 4'b0000;
    px(11'h123, 3'd3, 11'h045, 3'd5, 11'h000);
    idle_tick;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
